// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// The default half-period is derived from the nominal 50 MHz clock and 400 Hz output.
package clk_div_pkg;

  // Half-period register value for a 50% duty output: f_clk/(2*f_out) - 1.
  function automatic int calc_half(input longint unsigned f_clk,
                                   input longint unsigned f_out);
    return int'(f_clk / (64'd2 * f_out) - 64'd1);
  endfunction

  localparam int CLK_DIV_WIDTH    = 17;
  localparam int CLK_DIV_DEF_HALF = calc_half(64'd50_000_000, 64'd400);

  // Per-cycle action taken by one divider channel.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_COUNT = 2'd1,
    ACT_TERM  = 2'd2,
    ACT_CLEAR = 2'd3
  } chan_act_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, glitch-free half-period update,
// registered divided clock and toggle strobe.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               WIDTH    = CLK_DIV_WIDTH,
  parameter logic [WIDTH-1:0] HALF_RST = WIDTH'(CLK_DIV_DEF_HALF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_half,
  output logic             fout,
  output logic             tick,
  output logic             pend
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_half_act;
  logic [WIDTH-1:0] r_half_pend;
  logic             r_fout;
  logic             r_tick;
  logic             r_pend;

  logic             w_term;
  chan_act_e        w_act;

  assign w_term = (r_count == r_half_act);

  // NOTE: default assigned first so every path drives w_act and no latch is inferred.
  always_comb begin
    w_act = ACT_HOLD;
    if (sync_clr) begin
      w_act = ACT_CLEAR;
    end else if (en) begin
      w_act = w_term ? ACT_TERM : ACT_COUNT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_half_act  <= HALF_RST;
      r_half_pend <= HALF_RST;
      r_fout      <= 1'b0;
      r_tick      <= 1'b0;
      r_pend      <= 1'b0;
    end else begin
      unique case (w_act)
        ACT_CLEAR: begin
          r_count    <= '0;
          r_fout     <= 1'b0;
          r_tick     <= 1'b0;
          r_pend     <= 1'b0;
          // A write coinciding with the restart takes effect immediately.
          if (wr_en) begin
            r_half_act  <= wr_half;
            r_half_pend <= wr_half;
          end else begin
            r_half_act  <= r_half_pend;
          end
        end
        ACT_TERM: begin
          r_count <= '0;
          r_fout  <= ~r_fout;
          r_tick  <= 1'b1;
          if (r_pend) begin
            r_half_act <= r_half_pend;
            r_pend     <= 1'b0;
          end
        end
        ACT_COUNT: begin
          r_count <= r_count + 1'b1;
          r_tick  <= 1'b0;
        end
        default: begin
          r_tick <= 1'b0;
        end
      endcase

      // NOTE: placed after the case so that, when a write meets a terminal count,
      // the later non-blocking update to r_pend/r_half_pend wins.
      if (wr_en && (w_act != ACT_CLEAR)) begin
        r_half_pend <= wr_half;
        r_pend      <= 1'b1;
      end
    end
  end

  assign fout = r_fout;
  assign tick = r_tick;
  assign pend = r_pend;

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: CH independent channels sharing
// one half-period write port and a common synchronous restart.
module prog_clk_divider
  import clk_div_pkg::*;
#(
  parameter  int CH       = 4,
  parameter  int WIDTH    = CLK_DIV_WIDTH,
  parameter  int DEF_HALF = CLK_DIV_DEF_HALF,
  localparam int WCH      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH-1:0]    en,
  input  logic             sync_clr,
  input  logic             wr_en,
  input  logic [WCH-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_half,
  output logic [CH-1:0]    fout,
  output logic [CH-1:0]    tick,
  output logic [CH-1:0]    pend
);

  logic [CH-1:0] w_wr_sel;

  for (genvar g = 0; g < CH; g++) begin : g_chan
    // Selects at or beyond CH match no channel, so such writes are dropped.
    assign w_wr_sel[g] = wr_en && (wr_ch == WCH'(g));

    clk_div_chan #(
      .WIDTH    (WIDTH),
      .HALF_RST (WIDTH'(DEF_HALF))
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[g]),
      .sync_clr (sync_clr),
      .wr_en    (w_wr_sel[g]),
      .wr_half  (wr_half),
      .fout     (fout[g]),
      .tick     (tick[g]),
      .pend     (pend[g])
    );
  end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed bench for prog_clk_divider (CH=2, WIDTH=8, DEF_HALF=3).
// Cycle n means the n-th rising edge after reset release; outputs sampled 1 time unit later.
module tb_prog_clk_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] en;
  logic       sync_clr;
  logic       wr_en;
  logic [0:0] wr_ch;
  logic [7:0] wr_half;
  logic [1:0] fout, tick, pend;

  // With CH=2 the select is one bit, so the out-of-range write is exercised on a 3-channel copy.
  logic [2:0] en3;
  logic       wr_en3;
  logic [1:0] wr_ch3;
  logic [7:0] wr_half3;
  logic [2:0] fout3, tick3, pend3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prog_clk_divider #(.CH(2), .WIDTH(8), .DEF_HALF(3)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (sync_clr),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_half  (wr_half),
    .fout     (fout),
    .tick     (tick),
    .pend     (pend)
  );

  prog_clk_divider #(.CH(3), .WIDTH(8), .DEF_HALF(3)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en3),
    .sync_clr (1'b0),
    .wr_en    (wr_en3),
    .wr_ch    (wr_ch3),
    .wr_half  (wr_half3),
    .fout     (fout3),
    .tick     (tick3),
    .pend     (pend3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [0:0] ch, input logic [7:0] h);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_half = h;
    step(1);
    wr_en   = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 2'b11;
    sync_clr = 1'b0;
    wr_en    = 1'b0;
    wr_ch    = '0;
    wr_half  = '0;
    en3      = 3'b111;
    wr_en3   = 1'b0;
    wr_ch3   = '0;
    wr_half3 = '0;

    #23;
    check("rst_fout", fout, 2'b00);
    check("rst_tick", tick, 2'b00);
    check("rst_pend", pend, 2'b00);
    check("rst_fout3", fout3, 3'b000);
    #5 rst_n = 1'b1;

    // Basic H=3 division on both channels: edges at 4, 8, 12.
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check($sformatf("a_fout0_c%0d", k), fout[0], ((k >= 4 && k < 8) || k >= 12));
      check($sformatf("a_tick0_c%0d", k), tick[0], (k % 4 == 0));
      check($sformatf("a_fout1_c%0d", k), fout[1], ((k >= 4 && k < 8) || k >= 12));
    end

    // Mid-period write of H=1 on ch0: current half finishes at 16, then 2-cycle halves.
    step(1);                                   // cycle 13, count0=1
    write(1'b0, 8'd1);                         // cycle 14
    check("b_pend0_c14", pend[0], 1'b1);
    step(1);                                   // 15
    check("b_pend0_c15", pend[0], 1'b1);
    check("b_tick0_c15", tick[0], 1'b0);
    check("b_fout0_c15", fout[0], 1'b1);
    step(1);                                   // 16
    check("b_tick0_c16", tick[0], 1'b1);
    check("b_fout0_c16", fout[0], 1'b0);
    check("b_pend0_c16", pend[0], 1'b0);
    step(1);                                   // 17
    check("b_tick0_c17", tick[0], 1'b0);
    step(1);                                   // 18
    check("b_tick0_c18", tick[0], 1'b1);
    check("b_fout0_c18", fout[0], 1'b1);
    step(2);                                   // 20
    check("b_fout0_c20", fout[0], 1'b0);
    check("b_fout1_c20", fout[1], 1'b1);
    check("b_tick1_c20", tick[1], 1'b1);
    check("b_pend1_c20", pend[1], 1'b0);

    // H=0 on ch1: applied at 24, then toggles every cycle with tick held high.
    write(1'b1, 8'd0);                         // 21
    check("c_pend1_c21", pend[1], 1'b1);
    check("c_tick1_c21", tick[1], 1'b0);
    step(3);                                   // 24
    check("c_pend1_c24", pend[1], 1'b0);
    check("c_tick1_c24", tick[1], 1'b1);
    check("c_fout1_c24", fout[1], 1'b0);
    for (int k = 25; k <= 28; k++) begin
      step(1);
      check($sformatf("c_tick1_c%0d", k), tick[1], 1'b1);
      check($sformatf("c_fout1_c%0d", k), fout[1], (k % 2 == 1));
    end
    check("c_fout0_c28", fout[0], 1'b0);

    // sync_clr with a coincident write: ch0 loads H=3 directly.
    sync_clr = 1'b1;
    write(1'b0, 8'd3);                         // 29
    sync_clr = 1'b0;
    check("d_fout_c29", fout, 2'b00);
    check("d_tick_c29", tick, 2'b00);
    check("d_pend_c29", pend, 2'b00);
    step(2);                                   // 31, count0=2
    en = 2'b10;
    for (int k = 32; k <= 36; k++) begin
      step(1);
      check($sformatf("d_fout0_c%0d", k), fout[0], 1'b0);
      check($sformatf("d_tick0_c%0d", k), tick[0], 1'b0);
      if (k == 33) begin
        check("d_fout1_c33", fout[1], 1'b0);
        check("d_tick1_c33", tick[1], 1'b1);
      end
    end
    en = 2'b11;
    step(1);                                   // 37
    check("d_tick0_c37", tick[0], 1'b0);
    check("d_fout0_c37", fout[0], 1'b0);
    step(1);                                   // 38
    check("d_tick0_c38", tick[0], 1'b1);
    check("d_fout0_c38", fout[0], 1'b1);

    // Write meets a terminal on ch1 (H=0), then sync_clr applies the pending H=2.
    write(1'b1, 8'd2);                         // 39
    check("e_pend1_c39", pend[1], 1'b1);
    check("e_tick1_c39", tick[1], 1'b1);
    check("e_fout_c39", fout, 2'b01);
    sync_clr = 1'b1;
    step(1);                                   // 40
    sync_clr = 1'b0;
    check("e_fout_c40", fout, 2'b00);
    check("e_tick_c40", tick, 2'b00);
    check("e_pend_c40", pend, 2'b00);
    step(2);                                   // 42
    check("e_fout_c42", fout, 2'b00);
    step(1);                                   // 43
    check("e_fout_c43", fout, 2'b10);
    check("e_tick_c43", tick, 2'b10);
    step(1);                                   // 44
    check("e_fout_c44", fout, 2'b11);
    check("e_tick_c44", tick, 2'b01);
    step(2);                                   // 46
    check("e_fout_c46", fout, 2'b01);
    check("e_tick_c46", tick, 2'b10);

    // Asynchronous reset mid-cycle with a pending write outstanding.
    write(1'b1, 8'd5);                         // 47
    check("f_pend1_c47", pend[1], 1'b1);
    step(1);                                   // 48
    check("f_tick_c48", tick, 2'b01);
    check("f_pend_c48", pend, 2'b10);
    #3 rst_n = 1'b0;
    #1;
    check("f_async_fout", fout, 2'b00);
    check("f_async_tick", tick, 2'b00);
    check("f_async_pend", pend, 2'b00);
    @(posedge clk);
    #3 rst_n = 1'b1;
    wr_en3   = 1'b1;
    wr_ch3   = 2'd3;
    wr_half3 = 8'd0;
    step(1);                                   // cycle 1 after release
    wr_en3   = 1'b0;
    check("g_pend3_c1", pend3, 3'b000);
    check("g_pend_c1", pend, 2'b00);
    step(2);                                   // 3
    check("g_fout_c3", fout, 2'b00);
    check("g_fout3_c3", fout3, 3'b000);
    step(1);                                   // 4
    check("g_fout_c4", fout, 2'b11);
    check("g_tick_c4", tick, 2'b11);
    check("g_fout3_c4", fout3, 3'b111);
    check("g_tick3_c4", tick3, 3'b111);
    step(4);                                   // 8
    check("g_fout_c8", fout, 2'b00);
    check("g_fout3_c8", fout3, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
